// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - data-memory request unit with posted-write queue and watchdog
module mem_request_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       i_hit,
    input  logic                       d_hit,
    input  logic                       cu_dren,
    input  logic                       cu_dwen,
    input  logic [ADDR_W-1:0]          cu_addr,
    input  logic [DATA_W-1:0]          cu_wdata,
    input  logic                       flush,
    output logic                       d_ren,
    output logic                       d_wen,
    output logic [ADDR_W-1:0]          d_addr,
    output logic [DATA_W-1:0]          d_store,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] wq_count,
    output logic                       wq_full,
    output logic                       timeout_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic [WD_W-1:0]   wd_cnt;
    logic              q_empty, push, pop, busy;

    assign q_empty  = (count == '0);
    assign wq_full  = (count == CNT_W'(DEPTH));
    assign wq_count = count;
    assign push     = i_hit & cu_dwen & ~wq_full;
    assign pop      = d_hit & d_wen;
    assign busy     = d_ren | d_wen;
    assign stall    = rd_pend | (cu_dwen & wq_full);

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_addr[wr_ptr] <= cu_addr;
            q_data[wr_ptr] <= cu_wdata;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flush wins over both completion and a fresh capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_pend <= 1'b0;
            rd_addr <= '0;
        end else if (flush) begin
            rd_pend <= 1'b0;
        end else if (rd_pend) begin
            if (d_hit & d_ren) rd_pend <= 1'b0;
        end else if (i_hit & cu_dren & ~cu_dwen) begin
            rd_pend <= 1'b1;
            rd_addr <= cu_addr;
        end
    end

    always_comb begin
        d_wen   = ~q_empty;
        d_ren   = rd_pend & q_empty;
        d_addr  = '0;
        d_store = '0;
        if (d_wen) begin
            d_addr  = q_addr[rd_ptr];
            d_store = q_data[rd_ptr];
        end else if (d_ren) begin
            d_addr  = rd_addr;
        end
    end

    // Counter saturates at TIMEOUT; error latches on the cycle it gets there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (!busy || d_hit) begin
            wd_cnt <= '0;
        end else begin
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
            if (TIMEOUT != 0 && wd_cnt == WD_LAST) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - self-checking bench for mem_request_unit
module tb_mem_request_unit;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        i_hit = 0, d_hit = 0, cu_dren = 0, cu_dwen = 0, flush = 0;
    logic [31:0] cu_addr = 0, cu_wdata = 0;

    logic        d_ren, d_wen, stall, wq_full, timeout_err;
    logic [31:0] d_addr, d_store;
    logic [2:0]  wq_count;
    logic        z_ren, z_wen, z_stall, z_full, z_err;
    logic [31:0] z_addr, z_store;
    logic [2:0]  z_count;

    int n_chk = 0;
    int n_fail = 0;

    mem_request_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .i_hit(i_hit), .d_hit(d_hit), .cu_dren(cu_dren),
        .cu_dwen(cu_dwen), .cu_addr(cu_addr), .cu_wdata(cu_wdata), .flush(flush),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store), .stall(stall),
        .wq_count(wq_count), .wq_full(wq_full), .timeout_err(timeout_err));

    mem_request_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .i_hit(i_hit), .d_hit(d_hit), .cu_dren(cu_dren),
        .cu_dwen(cu_dwen), .cu_addr(cu_addr), .cu_wdata(cu_wdata), .flush(flush),
        .d_ren(z_ren), .d_wen(z_wen), .d_addr(z_addr), .d_store(z_store), .stall(z_stall),
        .wq_count(z_count), .wq_full(z_full), .timeout_err(z_err));

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending stores plus load/watchdog bookkeeping.
    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    bit          m_pend;
    logic [31:0] m_raddr;
    int          m_wait;
    bit          m_err;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mq.delete();
            m_pend = 0; m_raddr = 0; m_wait = 0; m_err = 0;
        end else begin
            automatic int  sz        = mq.size();
            automatic bit  presented = (sz > 0) || m_pend;
            automatic bit  load_out  = m_pend && (sz == 0);
            automatic bit  do_push   = i_hit && cu_dwen && (sz < DEPTH);
            if (presented && !d_hit) begin
                m_wait++;
                if (m_wait >= TMO) m_err = 1;
            end else begin
                m_wait = 0;
            end
            if (d_hit && sz > 0) void'(mq.pop_front());
            if (do_push) mq.push_back('{cu_addr, cu_wdata});
            if (flush) m_pend = 0;
            else if (m_pend) begin
                if (d_hit && load_out) m_pend = 0;
            end else if (i_hit && cu_dren && !cu_dwen) begin
                m_pend = 1; m_raddr = cu_addr;
            end
        end
    end

    always @(negedge CLK) begin
        automatic bit          e_wen   = mq.size() > 0;
        automatic bit          e_ren   = m_pend && mq.size() == 0;
        automatic logic [31:0] e_addr  = e_wen ? mq[0].a : (e_ren ? m_raddr : 32'h0);
        automatic logic [31:0] e_store = e_wen ? mq[0].d : 32'h0;
        automatic bit          e_full  = mq.size() == DEPTH;
        automatic bit          e_stall = m_pend || (cu_dwen && e_full);
        chk("m_wen",   d_wen,   e_wen);
        chk("m_ren",   d_ren,   e_ren);
        chk("m_addr",  d_addr,  e_addr);
        chk("m_store", d_store, e_store);
        chk("m_count", wq_count, mq.size());
        chk("m_full",  wq_full, e_full);
        chk("m_stall", stall,   e_stall);
        chk("m_err",   timeout_err, m_err);
        chk("m0_outs", {z_ren, z_wen, z_addr, z_store}, {e_ren, e_wen, e_addr, e_store});
        chk("m0_ctl",  {z_count, z_full, z_stall, z_err}, {3'(mq.size()), e_full, e_stall, 1'b0});
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        i_hit = 1; cu_dwen = 1; cu_dren = 0; cu_addr = a; cu_wdata = d;
        step();
        i_hit = 0; cu_dwen = 0;
    endtask

    task automatic ld(input logic [31:0] a);
        i_hit = 1; cu_dren = 1; cu_dwen = 0; cu_addr = a;
        step();
        i_hit = 0; cu_dren = 0;
    endtask

    task automatic do_reset();
        nRST = 0; i_hit = 0; d_hit = 0; cu_dren = 0; cu_dwen = 0; flush = 0;
        step();
        nRST = 1;
        step();
    endtask

    initial begin
        step();
        chk("rst_outs", {d_ren, d_wen, d_addr, d_store, stall}, 67'h0);
        chk("rst_cnt",  {wq_count, wq_full, timeout_err}, 5'h0);
        nRST = 1;
        step();

        // Posted stores drain in order
        d_hit = 0;
        st(32'h10, 1); st(32'h14, 2); st(32'h18, 3);
        chk("ps_cnt", wq_count, 3);
        chk("ps_head", {d_wen, d_addr, d_store, stall}, {1'b1, 32'h10, 32'h1, 1'b0});
        d_hit = 1;
        step(); chk("ps_pop1", {wq_count, d_addr, d_store}, {3'd2, 32'h14, 32'h2});
        step(); chk("ps_pop2", {wq_count, d_addr, d_store}, {3'd1, 32'h18, 32'h3});
        step(); chk("ps_pop3", {wq_count, d_wen}, {3'd0, 1'b0});
        d_hit = 0;

        // Full queue refuses pushes, even alongside a pop
        for (int i = 0; i < 4; i++) st(32'h30 + 4 * i, 10 + i);
        i_hit = 1; cu_dwen = 1; cu_addr = 32'h40; cu_wdata = 99;
        chk("fq_full", {wq_full, stall, wq_count}, {1'b1, 1'b1, 3'd4});
        d_hit = 1;
        step(); chk("fq_poponly", wq_count, 3);
        d_hit = 0; cu_addr = 32'h44; cu_wdata = 14;
        step(); chk("fq_push", wq_count, 4);
        i_hit = 0; cu_dwen = 0; d_hit = 1;
        step(); chk("fq_d0", d_addr, 32'h38);
        step(); chk("fq_d1", d_addr, 32'h3C);
        step(); chk("fq_d2", {d_addr, d_store}, {32'h44, 32'd14});
        step(); chk("fq_empty", {d_wen, wq_count}, {1'b0, 3'd0});
        d_hit = 0;

        // Load waits behind queued stores
        st(32'h50, 5); st(32'h54, 6); ld(32'h20);
        chk("lo_wait", {d_ren, d_wen, stall}, {1'b0, 1'b1, 1'b1});
        d_hit = 1;
        step(); chk("lo_wait2", {d_ren, wq_count}, {1'b0, 3'd1});
        step(); chk("lo_issue", {d_ren, d_wen, d_addr}, {1'b1, 1'b0, 32'h20});
        step(); chk("lo_done", {d_ren, stall}, 2'b00);
        d_hit = 0;

        // Flush cancels the load but leaves the store
        st(32'h60, 7); ld(32'h70);
        chk("fl_pre", {stall, d_wen}, 2'b11);
        flush = 1;
        step(); flush = 0;
        chk("fl_post", {stall, d_ren, d_wen, wq_count}, {1'b0, 1'b0, 1'b1, 3'd1});
        d_hit = 1;
        step(); chk("fl_drain", {d_ren, d_wen}, 2'b00);
        d_hit = 0;

        // Watchdog
        do_reset();
        ld(32'hA0);
        for (int i = 0; i < 7; i++) step();
        chk("wd_7", timeout_err, 0);
        step(); chk("wd_8", {timeout_err, z_err, d_ren}, 3'b101);
        d_hit = 1;
        step(); chk("wd_sticky", {timeout_err, z_err, d_ren}, 3'b100);
        d_hit = 0;

        // Async reset mid-drain
        do_reset();
        st(32'h80, 1); st(32'h84, 2); ld(32'h90);
        d_hit = 1;
        chk("ar_pre", {wq_count, stall}, {3'd2, 1'b1});
        #2 nRST = 0;
        #1;
        chk("ar_outs", {d_ren, d_wen, d_addr, d_store, stall}, 67'h0);
        chk("ar_cnt",  {wq_count, wq_full, timeout_err}, 5'h0);
        d_hit = 0;
        step(); nRST = 1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            i_hit    = ($urandom_range(0, 9) < 7);
            cu_dwen  = ($urandom_range(0, 9) < 4);
            cu_dren  = ($urandom_range(0, 9) < 4);
            d_hit    = ($urandom_range(0, 9) < (i < 1500 ? 5 : 2));
            flush    = ($urandom_range(0, 19) == 0);
            cu_addr  = $urandom;
            cu_wdata = $urandom;
            step();
        end
        i_hit = 0; cu_dwen = 0; cu_dren = 0; d_hit = 0; flush = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
